alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 150 +++++++++++++++
 tb/tb_alu_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequencer that runs 8-bit or 16-bit ALU commands through an external 8-bit ALU,
// low byte first, with a valid/ready handshake on both command and result sides.
module alu_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic        cmd_wide,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic        cmd_cin,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_carry,
  output logic        res_zero,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_carry,
  output logic [3:0]  alu_op,
  input  logic [7:0]  alu_c,
  input  logic        alu_carry_out,
  input  logic        alu_zero
);

  // state  | meaning
  // IDLE   | waiting for a command, cmd_ready high
  // LO     | low byte on the ALU
  // HI     | high byte on the ALU (wide commands only)
  // DONE   | result held until res_ready
  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_ADC    = 4'd1;
  localparam logic [3:0] OP_PASS_A = 4'd8;

  state_t state, state_nxt;

  logic [3:0]  op_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        cin_q;
  logic        wide_q;
  logic [7:0]  lo_c_q;
  logic        lo_carry_q;
  logic        lo_zero_q;
  logic [15:0] res_data_q;
  logic        res_carry_q;
  logic        res_zero_q;
  logic        accept;
  logic        chain_carry;

  // Subtract-family ops have no meaningful carry chain across bytes here, so they run narrow.
  function automatic logic narrow_only(input logic [3:0] op);
    return op inside {4'd2, 4'd3, 4'd10, 4'd11};
  endfunction

  assign cmd_ready   = (state == S_IDLE) && !reset;
  assign accept      = cmd_valid && cmd_ready;
  assign res_valid   = (state == S_DONE);
  assign res_data    = res_data_q;
  assign res_carry   = res_carry_q;
  assign res_zero    = res_zero_q;
  assign chain_carry = (op_q == OP_ADD) || (op_q == OP_ADC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_op    = OP_PASS_A;
    alu_carry = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_LO;
      end
      S_LO: begin
        alu_a     = a_q[7:0];
        alu_b     = b_q[7:0];
        alu_op    = op_q;
        alu_carry = cin_q;
        state_nxt = wide_q ? S_HI : S_DONE;
      end
      S_HI: begin
        alu_a = a_q[15:8];
        alu_b = b_q[15:8];
        if (chain_carry) begin
          alu_op    = OP_ADC;
          alu_carry = lo_carry_q;
        end else begin
          alu_op    = op_q;
          alu_carry = cin_q;
        end
        state_nxt = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q        <= 4'd0;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      cin_q       <= 1'b0;
      wide_q      <= 1'b0;
      lo_c_q      <= 8'h00;
      lo_carry_q  <= 1'b0;
      lo_zero_q   <= 1'b0;
      res_data_q  <= 16'h0000;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= cmd_op;
        a_q    <= cmd_a;
        b_q    <= cmd_b;
        cin_q  <= cmd_cin;
        wide_q <= cmd_wide && !narrow_only(cmd_op);
      end
      if (state == S_LO) begin
        lo_c_q     <= alu_c;
        lo_carry_q <= alu_carry_out;
        lo_zero_q  <= alu_zero;
        if (!wide_q) begin
          res_data_q  <= {8'h00, alu_c};
          res_carry_q <= alu_carry_out;
          res_zero_q  <= alu_zero;
        end
      end
      if (state == S_HI) begin
        res_data_q  <= {alu_c, lo_c_q};
        res_carry_q <= alu_carry_out;
        res_zero_q  <= alu_zero && lo_zero_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural 8-bit ALU, command-level result model checked every
// cycle, plus directed commands with hand-computed results and latencies.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = 4'd0;
  logic        cmd_wide = 1'b0;
  logic [15:0] cmd_a = 16'h0;
  logic [15:0] cmd_b = 16'h0;
  logic        cmd_cin = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [15:0] res_data;
  logic        res_carry;
  logic        res_zero;
  logic [7:0]  alu_a, alu_b, alu_c;
  logic        alu_carry, alu_carry_out, alu_zero;
  logic [3:0]  alu_op;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_seq dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_wide(cmd_wide),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_zero(res_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_carry(alu_carry), .alu_op(alu_op),
    .alu_c(alu_c), .alu_carry_out(alu_carry_out), .alu_zero(alu_zero)
  );

  // External ALU: {carry, result}; subtract-type carries are borrows.
  function automatic logic [8:0] alu8(input logic [3:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic c);
    logic [8:0] r;
    case (op)
      4'd0:    r = {1'b0, a} + {1'b0, b};
      4'd1:    r = {1'b0, a} + {1'b0, b} + {8'h00, c};
      4'd2:    r = {(a < b), 8'(a - b)};
      4'd3:    r = {({1'b0, a} < ({1'b0, b} + {8'h00, c})), 8'(a - b - {7'h00, c})};
      4'd4:    r = {1'b0, a | b};
      4'd5:    r = {1'b0, a & b};
      4'd6:    r = {1'b0, ~a};
      4'd7:    r = {1'b0, a ^ b};
      4'd9:    r = {1'b0, b};
      4'd10:   r = {(a != 8'h00), 8'(8'h00 - a)};
      4'd11:   r = {(a < b), 8'(a - b)};
      default: r = {1'b0, a};
    endcase
    return r;
  endfunction

  always_comb begin
    logic [8:0] t;
    t             = alu8(alu_op, alu_a, alu_b, alu_carry);
    alu_c         = t[7:0];
    alu_carry_out = t[8];
    alu_zero      = (t[7:0] == 8'h00);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Command-level model: busy flag, remaining compute cycles, and the whole 16-bit answer.
  bit          m_busy = 1'b0;
  int          m_wait = 0;
  bit          m_wide;
  logic [3:0]  m_op;
  logic [15:0] m_a, m_b;
  logic        m_cin, m_lo_carry;
  logic [15:0] m_data;
  logic        m_carry, m_zero;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0;
      m_wait = 0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        logic [8:0] lo, hi;
        m_busy = 1'b1;
        m_op   = cmd_op;
        m_a    = cmd_a;
        m_b    = cmd_b;
        m_cin  = cmd_cin;
        m_wide = cmd_wide && !(cmd_op inside {4'd2, 4'd3, 4'd10, 4'd11});
        lo = alu8(m_op, m_a[7:0], m_b[7:0], m_cin);
        m_lo_carry = lo[8];
        if (m_wide) begin
          if (m_op <= 4'd1) hi = alu8(4'd1, m_a[15:8], m_b[15:8], lo[8]);
          else              hi = alu8(m_op, m_a[15:8], m_b[15:8], m_cin);
          m_data  = {hi[7:0], lo[7:0]};
          m_carry = hi[8];
          m_wait  = 2;
        end else begin
          m_data  = {8'h00, lo[7:0]};
          m_carry = lo[8];
          m_wait  = 1;
        end
        m_zero = (m_data == 16'h0000);
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (res_ready) begin
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_cmd_ready", cmd_ready, !reset && !m_busy);
      chk("m_res_valid", res_valid, m_busy && m_wait == 0);
      if (m_busy && m_wait == 0)
        chk("m_result", {res_data, res_carry, res_zero}, {m_data, m_carry, m_zero});
      if (!m_busy || m_wait == 0)
        chk("m_alu_quiet", {alu_op, alu_a, alu_b, alu_carry}, {4'd8, 8'h00, 8'h00, 1'b0});
      else if ((m_wide ? 2 : 1) - m_wait == 0)
        chk("m_alu_lo", {alu_op, alu_a, alu_b, alu_carry}, {m_op, m_a[7:0], m_b[7:0], m_cin});
      else
        chk("m_alu_hi", {alu_op, alu_a, alu_b, alu_carry},
            {(m_op <= 4'd1) ? 4'd1 : m_op, m_a[15:8], m_b[15:8],
             (m_op <= 4'd1) ? m_lo_carry : m_cin});
    end
  end

  // Issues one command, scrambles cmd_* after acceptance, checks literal result and latency,
  // optionally holds res_ready low for `hold` cycles while offering another command.
  task automatic run_cmd(input logic [3:0] op, input logic w, input logic [15:0] a,
                         input logic [15:0] b, input logic cin, input logic [15:0] ed,
                         input logic ec, input logic ez, input int el, input int hold);
    bit got;
    int acc;
    cmd_op = op; cmd_wide = w; cmd_a = a; cmd_b = b; cmd_cin = cin;
    cmd_valid = 1'b1;
    res_ready = (hold == 0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (cmd_ready) got = 1'b1;
    end
    chk("accept", got, 1'b1);
    acc = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = ~op; cmd_wide = ~w; cmd_a = ~a; cmd_b = a ^ b; cmd_cin = ~cin;
    if (!got) return;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (res_valid) got = 1'b1;
    end
    chk("res_wait", got, 1'b1);
    if (!got) return;
    chk("latency", cyc - acc, el);
    chk("lit_result", {res_data, res_carry, res_zero}, {ed, ec, ez});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      @(negedge clk);
      chk("bp_valid", res_valid, 1'b1);
      chk("bp_result", {res_data, res_carry, res_zero}, {ed, ec, ez});
      chk("bp_cmd_ready", cmd_ready, 1'b0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 16'h1111; cmd_b = 16'h2222;
    repeat (3) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_outputs", {res_valid, res_data, res_carry, res_zero}, 19'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rel_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;

    //      op     w     a         b         cin   data      c     z     lat hold
    run_cmd(4'd0,  1'b0, 16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b0, 2, 0);
    run_cmd(4'd0,  1'b1, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 3, 0);
    run_cmd(4'd0,  1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 3, 0);
    run_cmd(4'd1,  1'b1, 16'h1234, 16'h0001, 1'b1, 16'h1236, 1'b0, 1'b0, 3, 0);
    run_cmd(4'd5,  1'b1, 16'hF0F0, 16'hFF00, 1'b0, 16'hF000, 1'b0, 1'b0, 3, 0);
    run_cmd(4'd2,  1'b1, 16'h0105, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 2, 0);
    run_cmd(4'd2,  1'b0, 16'h7703, 16'h0005, 1'b0, 16'h00FE, 1'b1, 1'b0, 2, 0);
    run_cmd(4'd7,  1'b1, 16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 1'b0, 1'b1, 3, 0);
    run_cmd(4'd8,  1'b1, 16'h1200, 16'hFFFF, 1'b0, 16'h1200, 1'b0, 1'b0, 3, 0);
    run_cmd(4'd4,  1'b0, 16'h000F, 16'h00F0, 1'b0, 16'h00FF, 1'b0, 1'b0, 2, 5);
    run_cmd(4'd12, 1'b1, 16'hBEEF, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b0, 3, 0);
    run_cmd(4'd10, 1'b1, 16'h0001, 16'h0000, 1'b0, 16'h00FF, 1'b1, 1'b0, 2, 0);
    run_cmd(4'd3,  1'b1, 16'h0010, 16'h0010, 1'b1, 16'h00FF, 1'b1, 1'b0, 2, 0);
    run_cmd(4'd1,  1'b1, 16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 3, 0);
    run_cmd(4'd6,  1'b1, 16'h00FF, 16'h0000, 1'b0, 16'hFF00, 1'b0, 1'b0, 3, 4);
    run_cmd(4'd9,  1'b0, 16'h1234, 16'hABCD, 1'b0, 16'h00CD, 1'b0, 1'b0, 2, 0);

    // Reset while the high byte of a wide command is on the ALU.
    cmd_op = 4'd0; cmd_wide = 1'b1; cmd_a = 16'h00FF; cmd_b = 16'h0001; cmd_cin = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    chk("rm_accept_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rm_in_hi", {alu_op, alu_a, alu_b}, {4'd1, 8'h00, 8'h00});
    @(posedge clk);
    @(negedge clk);
    chk("rm_res_valid", res_valid, 1'b0);
    chk("rm_res_data", res_data, 16'h0000);
    chk("rm_cmd_ready_held", cmd_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rm_cmd_ready_rel", cmd_ready, 1'b1);
    @(posedge clk); #1;

    run_cmd(4'd0,  1'b1, 16'h0180, 16'h0080, 1'b0, 16'h0200, 1'b0, 1'b0, 3, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
